// File: rtl/ins_fetch_mem_pkg.sv
// ins_mem_pkg: shared definitions for the instruction fetch memory.
//   fetch_state_t    - fetch FSM states
//   IMG_FLD_*_OFF    - per-field index offsets of the power-up image
//   img_lsb()        - bit position of an image field for a given REG_W
//   img_field()      - value of an image field for a given word index
//   LATENCY_MIN/MAX  - legal read latency range
//   CNT_W            - latency counter width (covers 0..LATENCY_MAX-1)
package ins_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Field 0 is the low field, field 2 the high field. Each field holds
  // (word index + offset) mod 2**REG_W.
  localparam int IMG_FLD_LO_OFF  = 2;
  localparam int IMG_FLD_MID_OFF = 1;
  localparam int IMG_FLD_HI_OFF  = 0;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  localparam int CNT_W       = 2;

  function automatic int unsigned img_lsb(input int unsigned reg_w,
                                          input int unsigned fld);
    return fld * reg_w;
  endfunction

  function automatic int unsigned img_field(input int unsigned idx,
                                            input int unsigned off,
                                            input int unsigned reg_w);
    return (idx + off) & ((32'd1 << reg_w) - 32'd1);
  endfunction

endpackage

// File: rtl/ins_fetch_mem_if.sv
// ins_fetch_mem_if: fetch request/response handshake plus program-load
// write port between the fetch logic (master) and ins_fetch_mem (slave).
//   req_valid/req_ready/req_addr - fetch request
//   rsp_valid/rsp_ready/ins      - fetch response
//   prog_we/prog_addr/prog_data  - run-time program load
interface ins_fetch_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] ins;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  modport master (
    output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid, ins
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid, ins
  );
endinterface

// File: rtl/ins_fetch_mem_array.sv
// ins_mem_array: single-write, single-read synchronous RAM.
//   clk, rst      - clock; rst clears only the read data register
//   we/waddr/wdata - write port, every rising edge with we=1
//   re/raddr/rdata - registered read, updated only when re=1
// Contents come up holding the default register-index image and are never
// touched by rst. A read and write to the same address on one edge returns
// the new data.
module ins_mem_array
  import ins_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  typedef logic [DEPTH-1:0][DATA_W-1:0] image_t;

  function automatic image_t default_image();
    image_t img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) begin
      img[i][img_lsb(REG_W, 0) +: REG_W] = REG_W'(img_field(i, IMG_FLD_LO_OFF,  REG_W));
      img[i][img_lsb(REG_W, 1) +: REG_W] = REG_W'(img_field(i, IMG_FLD_MID_OFF, REG_W));
      img[i][img_lsb(REG_W, 2) +: REG_W] = REG_W'(img_field(i, IMG_FLD_HI_OFF,  REG_W));
    end
    return img;
  endfunction

  // Power-up image only; there is deliberately no reset path for contents.
  image_t mem = default_image();

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ins_fetch_mem.sv
// ins_fetch_mem: instruction memory with a LATENCY-cycle registered read and
// a request/valid handshake, single outstanding request.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset of control state (not contents)
//   bus  - ins_fetch_mem_if slave: fetch request, response, program load
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request (unless a program write is in progress)
// BUSY  | request latched, counting down latency; read issued when cnt=0
// HOLD  | ins valid and held until the consumer takes it
module ins_fetch_mem
  import ins_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int LATENCY = 1
) (
  input logic clk,
  input logic rst,
  ins_fetch_mem_if.slave bus
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_lat_chk
    $error("ins_fetch_mem: LATENCY must be within 1..4");
  end
  if (3 * REG_W > DATA_W) begin : g_reg_chk
    $error("ins_fetch_mem: three REG_W fields do not fit in DATA_W");
  end

  fetch_state_t      state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              rd_en;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    rd_en     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        // A program write blocks acceptance so the two never share an edge.
        req_ready = ~bus.prog_we;
        if (bus.req_valid && !bus.prog_we) begin
          addr_nxt  = bus.req_addr;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          rd_en     = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  ins_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.prog_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .re    (rd_en),
    .raddr (addr_q),
    .rdata (rd_data)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.ins       = rd_data;

endmodule

// File: tb/tb_ins_fetch_mem.sv
// tb_ins_fetch_mem: three ins_fetch_mem instances (LATENCY 1, 3, 2) sharing
// clk/rst. Expected instructions come from a bench-side memory model and are
// queued when a request is driven, then popped when rsp_valid is seen.
module tb_ins_fetch_mem;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic logic [15:0] img(input int i);
    logic [15:0] w;
    w      = '0;
    w[2:0] = 3'((i + 2) % 8);
    w[5:3] = 3'((i + 1) % 8);
    w[8:6] = 3'(i % 8);
    return w;
  endfunction

  logic clk;
  logic rst;

  logic        req_valid [3];
  logic        req_ready [3];
  logic [7:0]  req_addr  [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] ins       [3];
  logic        prog_we   [3];
  logic [7:0]  prog_addr [3];
  logic [15:0] prog_data [3];

  logic [15:0] mdl [3][256];
  logic [15:0] sbq [$];
  logic [15:0] e;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ins_fetch_mem_if #(.ADDR_W(8), .DATA_W(16)) u_bus ();

    assign u_bus.req_valid = req_valid[g];
    assign u_bus.req_addr  = req_addr[g];
    assign u_bus.rsp_ready = rsp_ready[g];
    assign u_bus.prog_we   = prog_we[g];
    assign u_bus.prog_addr = prog_addr[g];
    assign u_bus.prog_data = prog_data[g];
    assign req_ready[g]    = u_bus.req_ready;
    assign rsp_valid[g]    = u_bus.rsp_valid;
    assign ins[g]          = u_bus.ins;

    ins_fetch_mem #(
      .ADDR_W  (8),
      .DATA_W  (16),
      .REG_W   (3),
      .LATENCY (lat_of(g))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full fetch on instance k, called at a falling edge. Optionally holds
  // rsp_ready low for 'hold' cycles and, with chain=1, presents the next
  // request (a2) during the hold so its non-acceptance is observed.
  task automatic fetch(input int k, input logic [7:0] a, input logic [15:0] exp,
                       input int hold, input bit chain, input logic [7:0] a2);
    int n;
    logic [15:0] ex;
    sbq.push_back(exp);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    rsp_ready[k] = 1'b0;
    #1;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("accept", 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 0;
    while (rsp_valid[k] !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    check("latency", n, lat_of(k));
    check("sb_size", sbq.size(), 32'd1);
    ex = (sbq.size() != 0) ? sbq.pop_front() : 16'hxxxx;
    check("ins", 32'(ins[k]), 32'(ex));
    if (chain) begin
      req_valid[k] = 1'b1;
      req_addr[k]  = a2;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ins", 32'(ins[k]), 32'(ex));
      check("hold_vld", 32'(rsp_valid[k]), 32'd1);
      check("hold_rdy", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check("done_vld", 32'(rsp_valid[k]), 32'd0);
    check("done_rdy", 32'(req_ready[k]), 32'd1);
  endtask

  // Start a request, wait wait_cyc falling edges past acceptance, then pulse
  // rst between clock edges and check the control outputs drop at once.
  task automatic reset_during(input int k, input logic [7:0] a, input int wait_cyc,
                              input logic vld_before);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    #1 check("rr_acc", 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    repeat (wait_cyc) @(negedge clk);
    check("rr_pre_vld", 32'(rsp_valid[k]), 32'(vld_before));
    check("rr_pre_rdy", 32'(req_ready[k]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rr_vld", 32'(rsp_valid[k]), 32'd0);
    check("rr_rdy", 32'(req_ready[k]), 32'd1);
    check("rr_ins", 32'(ins[k]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = '0;
      rsp_ready[k] = 1'b0;
      prog_we[k]   = 1'b0;
      prog_addr[k] = '0;
      prog_data[k] = '0;
      for (int i = 0; i < 256; i++) mdl[k][i] = img(i);
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      check("rst_rdy", 32'(req_ready[k]), 32'd1);
      check("rst_vld", 32'(rsp_valid[k]), 32'd0);
      check("rst_ins", 32'(ins[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Default image reads at several latencies, including the top address.
    fetch(0, 8'h05, mdl[0][8'h05], 0, 1'b0, 8'h00);
    fetch(1, 8'hFF, mdl[1][8'hFF], 5, 1'b1, 8'h00);
    fetch(1, 8'h00, mdl[1][8'h00], 0, 1'b0, 8'h00);
    fetch(2, 8'h07, mdl[2][8'h07], 1, 1'b0, 8'h00);
    fetch(0, 8'h80, mdl[0][8'h80], 2, 1'b0, 8'h00);

    // Program write with a simultaneous request: request waits one cycle.
    prog_we[0]   = 1'b1;
    prog_addr[0] = 8'h10;
    prog_data[0] = 16'hBEEF;
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'h10;
    #1 check("we_blocks_rdy", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    prog_we[0] = 1'b0;
    mdl[0][8'h10] = 16'hBEEF;
    #1 check("rdy_after_we", 32'(req_ready[0]), 32'd1);
    fetch(0, 8'h10, mdl[0][8'h10], 0, 1'b0, 8'h00);

    // LATENCY=2: write on the final BUSY edge is seen, write in HOLD is not.
    sbq.push_back(16'h1234);
    req_valid[2] = 1'b1;
    req_addr[2]  = 8'h33;
    #1 check("raw_acc", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("raw_busy_vld", 32'(rsp_valid[2]), 32'd0);
    prog_we[2]   = 1'b1;
    prog_addr[2] = 8'h33;
    prog_data[2] = 16'h1234;
    @(negedge clk);
    prog_we[2] = 1'b0;
    mdl[2][8'h33] = 16'h1234;
    check("raw_vld", 32'(rsp_valid[2]), 32'd1);
    check("raw_sb_size", sbq.size(), 32'd1);
    e = (sbq.size() != 0) ? sbq.pop_front() : 16'hxxxx;
    check("raw_ins", 32'(ins[2]), 32'(e));
    prog_we[2]   = 1'b1;
    prog_data[2] = 16'hABCD;
    @(negedge clk);
    prog_we[2] = 1'b0;
    mdl[2][8'h33] = 16'hABCD;
    check("hold_wr_ins", 32'(ins[2]), 32'(e));
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    rsp_ready[2] = 1'b0;
    check("raw_done_vld", 32'(rsp_valid[2]), 32'd0);
    fetch(2, 8'h33, mdl[2][8'h33], 0, 1'b0, 8'h00);

    // Asynchronous reset mid-BUSY and mid-HOLD; contents survive.
    reset_during(0, 8'h10, 0, 1'b0);
    reset_during(1, 8'h20, 3, 1'b1);
    fetch(0, 8'h10, mdl[0][8'h10], 0, 1'b0, 8'h00);
    fetch(2, 8'h33, mdl[2][8'h33], 0, 1'b0, 8'h00);
    fetch(1, 8'h20, mdl[1][8'h20], 0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
